// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes, state encodings and helpers for keypad UI stages
package keypad_pkg;

    localparam logic [3:0] KEY_BACK  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    // One-hot, matching the scanner FSM encoding style.
    typedef enum logic [2:0] {
        S_EMPTY = 3'b001,
        S_ENTRY = 3'b010,
        S_HOLD  = 3'b100
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - enabled inactivity counter with synchronous restart and expiry strobe
module idle_timer #(
    parameter int LIMIT = 99,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic expire
);

    logic [W-1:0] count;

    // Strobe on the cycle whose closing edge brings the count to LIMIT.
    assign expire = en && !restart && (count == W'(LIMIT - 1));

    // Count while enabled; any restart, disable or expiry returns to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!en || restart || expire) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/key_entry_buffer.sv
// rtl/key_entry_buffer.sv - assembles keypad digits into a decimal entry with valid/ready output
module key_entry_buffer
    import keypad_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_flag,
    input  logic [3:0]          key_value,
    input  logic                entry_ready,
    output logic                entry_valid,
    output logic [4*DIGITS-1:0] entry_data,
    output logic [3:0]          entry_len,
    output logic [4*DIGITS-1:0] disp_data,
    output logic [3:0]          disp_len,
    output logic                overflow_err,
    output logic                timeout_pulse
);

    localparam int         DW      = 4 * DIGITS;
    localparam int         TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] MAX_LEN = 4'(DIGITS);

    state_t          state;
    logic [DW-1:0]   digit_buf;
    logic [3:0]      len;
    logic            timer_en;
    logic            timer_restart;
    logic            timer_expire;
    logic            key_digit;
    logic            key_back;
    logic            key_enter;
    logic            key_clear;

    assign key_digit = key_flag && is_digit(key_value);
    assign key_back  = key_flag && (key_value == KEY_BACK);
    assign key_enter = key_flag && (key_value == KEY_ENTER);
    assign key_clear = key_flag && (key_value == KEY_CLEAR);

    // Only entry-editing keys count as activity; D/E/F leave the timer running.
    assign timer_en      = (state == S_ENTRY);
    assign timer_restart = key_digit || key_back || key_enter;

    idle_timer #(
        .LIMIT (TIMEOUT_CYCLES - 1),
        .W     (TW)
    ) u_idle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (timer_en),
        .restart (timer_restart),
        .expire  (timer_expire)
    );

    assign disp_data = digit_buf;
    assign disp_len  = len;

    // Entry FSM: key handling, hold/handshake and inactivity clear, all registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_EMPTY;
            digit_buf     <= '0;
            len           <= '0;
            entry_valid   <= 1'b0;
            entry_data    <= '0;
            entry_len     <= '0;
            overflow_err  <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            overflow_err  <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                S_EMPTY, S_ENTRY: begin
                    if (key_digit) begin
                        if (len < MAX_LEN) begin
                            digit_buf <= (digit_buf << 4) | DW'(key_value);
                            len       <= len + 4'd1;
                            state     <= S_ENTRY;
                        end else begin
                            overflow_err <= 1'b1;
                        end
                    end else if (key_back) begin
                        if (len != 4'd0) begin
                            digit_buf <= digit_buf >> 4;
                            len       <= len - 4'd1;
                            if (len == 4'd1) begin
                                state <= S_EMPTY;
                            end
                        end
                    end else if (key_enter) begin
                        if (len != 4'd0) begin
                            entry_data  <= digit_buf;
                            entry_len   <= len;
                            entry_valid <= 1'b1;
                            state       <= S_HOLD;
                        end
                    end else if (key_clear) begin
                        digit_buf <= '0;
                        len       <= '0;
                        state     <= S_EMPTY;
                    end else if (timer_expire) begin
                        digit_buf     <= '0;
                        len           <= '0;
                        state         <= S_EMPTY;
                        timeout_pulse <= 1'b1;
                    end
                end
                S_HOLD: begin
                    // A transfer swallows any key arriving with it, clear included.
                    if ((entry_valid && entry_ready) || key_clear) begin
                        entry_valid <= 1'b0;
                        digit_buf   <= '0;
                        len         <= '0;
                        state       <= S_EMPTY;
                    end
                end
                default: begin
                    entry_valid <= 1'b0;
                    digit_buf   <= '0;
                    len         <= '0;
                    state       <= S_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_buffer.sv
// tb/tb_key_entry_buffer.sv - directed self-checking bench for key_entry_buffer
module tb_key_entry_buffer;

    localparam int DIGITS         = 4;
    localparam int TIMEOUT_CYCLES = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_flag = 1'b0;
    logic [3:0]  key_value = 4'h0;
    logic        entry_ready = 1'b0;
    logic        entry_valid;
    logic [15:0] entry_data;
    logic [3:0]  entry_len;
    logic [15:0] disp_data;
    logic [3:0]  disp_len;
    logic        overflow_err;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;

    key_entry_buffer #(
        .DIGITS         (DIGITS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_flag      (key_flag),
        .key_value     (key_value),
        .entry_ready   (entry_ready),
        .entry_valid   (entry_valid),
        .entry_data    (entry_data),
        .entry_len     (entry_len),
        .disp_data     (disp_data),
        .disp_len      (disp_len),
        .overflow_err  (overflow_err),
        .timeout_pulse (timeout_pulse)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_flag  = 1'b1;
        key_value = k;
        @(posedge clk);
        #1;
        key_flag  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset values
        #25;
        check("rst_valid", entry_valid, 0);
        check("rst_edata", entry_data, 0);
        check("rst_elen", entry_len, 0);
        check("rst_disp", disp_data, 0);
        check("rst_dlen", disp_len, 0);
        check("rst_ovf", overflow_err, 0);
        check("rst_tmo", timeout_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: enter 123, hold stable, digits ignored
        press(4'h1); press(4'h2); press(4'h3);
        check("t1_disp", disp_data, 16'h0123);
        check("t1_dlen", disp_len, 3);
        press(4'hB);
        check("t1_valid", entry_valid, 1);
        check("t1_edata", entry_data, 16'h0123);
        check("t1_elen", entry_len, 3);
        idle(100);
        press(4'h5);
        press(4'hA);
        press(4'hB);
        check("t1_hold_valid", entry_valid, 1);
        check("t1_hold_edata", entry_data, 16'h0123);
        check("t1_hold_disp", disp_data, 16'h0123);
        check("t1_hold_dlen", disp_len, 3);
        check("t1_hold_ovf", overflow_err, 0);

        // 2: single-cycle handshake then a fresh digit
        entry_ready = 1'b1;
        @(posedge clk);
        #1;
        entry_ready = 1'b0;
        check("t2_valid", entry_valid, 0);
        check("t2_dlen", disp_len, 0);
        check("t2_disp", disp_data, 0);
        check("t2_edata_kept", entry_data, 16'h0123);
        check("t2_elen_kept", entry_len, 3);
        press(4'h7);
        check("t2_disp7", disp_data, 16'h0007);
        check("t2_dlen7", disp_len, 1);
        press(4'hC);

        // 3: overflow on fifth digit, then backspace
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        check("t3_ovf_pre", overflow_err, 0);
        press(4'h5);
        check("t3_ovf", overflow_err, 1);
        check("t3_disp", disp_data, 16'h9876);
        check("t3_dlen", disp_len, 4);
        idle(1);
        check("t3_ovf_once", overflow_err, 0);
        press(4'hA);
        check("t3_back", disp_data, 16'h0987);
        check("t3_back_len", disp_len, 3);
        press(4'hC);

        // 4: clear, ignored keys in empty and entry
        press(4'h4); press(4'h5);
        check("t4_disp45", disp_data, 16'h0045);
        press(4'hC);
        check("t4_clr_len", disp_len, 0);
        check("t4_clr_disp", disp_data, 0);
        press(4'hB);
        check("t4_enter_empty", entry_valid, 0);
        press(4'hA);
        press(4'hD); press(4'hE); press(4'hF);
        check("t4_empty_len", disp_len, 0);
        press(4'h2);
        press(4'hD); press(4'hE); press(4'hF);
        check("t4_def_disp", disp_data, 16'h0002);
        check("t4_def_len", disp_len, 1);
        press(4'h0);
        check("t4_lead0", disp_data, 16'h0020);
        check("t4_lead0_len", disp_len, 2);
        press(4'hC);

        // 5: inactivity timeout and key on expiry cycle
        press(4'h3);
        idle(98);
        check("t5_pre_tmo", timeout_pulse, 0);
        check("t5_pre_len", disp_len, 1);
        idle(1);
        check("t5_tmo", timeout_pulse, 1);
        check("t5_tmo_len", disp_len, 0);
        check("t5_tmo_disp", disp_data, 0);
        idle(1);
        check("t5_tmo_once", timeout_pulse, 0);
        press(4'h3);
        idle(98);
        press(4'h4);
        check("t5_key_wins", timeout_pulse, 0);
        check("t5_key_len", disp_len, 2);
        check("t5_key_disp", disp_data, 16'h0034);
        idle(1);
        check("t5_no_late", timeout_pulse, 0);
        press(4'hC);

        // 6: transfer together with clear key, then async reset mid-entry
        press(4'h1);
        press(4'hB);
        check("t6_hold", entry_valid, 1);
        key_flag    = 1'b1;
        key_value   = 4'hC;
        entry_ready = 1'b1;
        @(posedge clk);
        #1;
        key_flag    = 1'b0;
        entry_ready = 1'b0;
        check("t6_xfer_valid", entry_valid, 0);
        check("t6_xfer_len", disp_len, 0);
        check("t6_xfer_edata", entry_data, 16'h0001);
        idle(2);
        check("t6_one_xfer", entry_valid, 0);
        press(4'h6); press(4'h2);
        check("t6_entry", disp_data, 16'h0062);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_disp", disp_data, 0);
        check("t6_async_len", disp_len, 0);
        check("t6_async_elen", entry_len, 0);
        check("t6_async_edata", entry_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("t6_post_tmo", timeout_pulse, 0);
        check("t6_post_len", disp_len, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
